fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined RISC-V core. It owns the PC and issues instruction reads to the icache. It captures each returned instruction together with its PC and PC+4 and presents them, registered, to decode as `imemload`/`imemaddr`. It absorbs decode-side stalls with a one-entry skid buffer, accepts branch/jump redirects from later stages, and freezes permanently on halt.

## Interface
- `PC_INIT`, default 32'h0000_0000, reset value of the PC (bits [1:0] must be 0).

Ports:
- `CLK` in 1: core clock; all state updates on the rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `ihit` in 1: icache returns a valid `imemload` for the current `imemaddr` this cycle.
- `imemload` in 32 (`word_t`): instruction word from the icache.
- `imemREN` out 1: instruction read request.
- `imemaddr` out 32: fetch address, always equal to the PC.
- `stall` in 1: hazard unit holds IF/ID this cycle.
- `redirect` in 1: taken branch or jump resolved downstream.
- `redirect_pc` in 32: redirect target; bits [1:0] are ignored and treated as 0.
- `halt_in` in 1: halt observed downstream; fetch stops.
- `if_valid` out 1: IF/ID holds a real instruction. When 0, the slot is a bubble.
- `if_instr` out 32: IF/ID instruction; feeds decode `imemload`.
- `if_pc` out 32: PC of `if_instr`; feeds decode `imemaddr`.
- `if_npc` out 32: `if_pc + 4`, used for JAL/JALR link.

## Operation
- State machine states: FETCH, BUFFERED, HALTED. Internal registers: `pc`, `buf_instr`, `buf_pc`.
- `imemREN` = 1 only in FETCH. `imemaddr` = `pc` in every state.
- Per-cycle priority, highest first: `halt_in`, then `redirect`, then normal operation.
- `halt_in` = 1 in any state:
  - next state is HALTED and `if_valid` <= 0;
  - `pc` and the buffer are frozen.
  - HALTED is left only by reset. All inputs are ignored while in HALTED.
- `redirect` = 1 (and no halt):
  - `pc` <= {`redirect_pc`[31:2], 2'b00};
  - `if_valid` <= 0, whether or not `stall` is asserted;
  - the buffer is discarded and next state is FETCH;
  - any `ihit` in the same cycle is dropped.
- FETCH, with no halt and no redirect:
  - `ihit` & !`stall`: IF/ID <= {1, `imemload`, `pc`, `pc+4`}; `pc` <= `pc+4`.
  - `ihit` & `stall`: `buf_instr` <= `imemload`, `buf_pc` <= `pc`; `pc` <= `pc+4`; IF/ID is held; next state is BUFFERED.
  - !`ihit` & !`stall`: `if_valid` <= 0 (bubble); other IF/ID fields may hold.
  - !`ihit` & `stall`: everything holds.
- BUFFERED, with no halt and no redirect:
  - `stall`: everything holds.
  - !`stall`: IF/ID <= {1, `buf_instr`, `buf_pc`, `buf_pc+4`}; next state is FETCH.
- Arithmetic: all PC additions are 32-bit modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Reset (asynchronous, any time, including mid-miss or while BUFFERED):
  - state = FETCH, `pc` = `PC_INIT`;
  - `buf_instr` = 0, `buf_pc` = 0;
  - `if_valid` = 0, `if_instr` = 0, `if_pc` = 0, `if_npc` = 0.
  - As a result, `imemREN` = 1 and `imemaddr` = `PC_INIT` while reset is asserted and immediately after release.

## Timing
- IF/ID outputs are registered. An instruction hit in cycle N appears on `if_*` in cycle N+1.
- Throughput: one instruction per cycle while `ihit` = 1 and `stall` = 0.
- The PC advances on the edge ending the hit cycle. The new `imemaddr` is visible in cycle N+1.
- A stall arriving during a hit costs no refetch: the buffered word issues the cycle after `stall` falls.
- Redirect in cycle N:
  - `if_valid` = 0 and `imemaddr` = target in N+1;
  - the first target instruction is on `if_*` no earlier than N+2.
- `halt_in` in cycle N: `imemREN` = 0 and `if_valid` = 0 from N+1 onward.
- No combinational path from `stall`, `redirect` or `halt_in` to any output. `imemREN` and `imemaddr` depend only on registered state.

## Test plan
- Reset with `PC_INIT`=0, then `ihit`=1 every cycle with `imemload` = address XOR 32'hA5A5_A5A5 -> `if_pc` = 0, 4, 8, … on consecutive cycles, `if_npc` = `if_pc`+4, `if_valid`=1 from the second cycle on.
- Stall during a hit at `pc`=8, held 3 cycles -> state BUFFERED, `imemREN`=0, `imemaddr`=12, IF/ID unchanged. One cycle after `stall` drops, `if_pc`=8 with the correct word; then fetch resumes at 12 with no duplicated or skipped PC.
- `ihit`=0 for 4 cycles at `pc`=16 with no stall -> `if_valid`=0 for those cycles, `imemaddr` stays 16, and the instruction appears the cycle after `ihit` returns.
- `redirect`=1, `redirect_pc`=32'h0000_0103, asserted together with `stall` while BUFFERED -> next cycle `if_valid`=0, `imemaddr`=32'h0000_0100, state FETCH, buffered word never issued.
- `halt_in` pulsed for one cycle simultaneously with `redirect` -> `imemREN`=0 and `if_valid`=0 permanently, `pc` unchanged, later redirects ignored. Asserting `nRST` low restores FETCH at `PC_INIT`.
- `PC_INIT`=32'hFFFF_FFF8 with continuous hits -> `if_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. Also: asynchronous reset asserted mid-BUFFERED clears all outputs immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: icache request/response, hazard/redirect/halt controls
// from later stages, and the IF/ID register outputs toward decode.
interface fetch_if;
    typedef logic [31:0] word_t;

    // icache side
    logic  ihit;
    word_t imemload;
    logic  imemREN;
    word_t imemaddr;

    // control from hazard unit and later stages
    logic  stall;
    logic  redirect;
    word_t redirect_pc;
    logic  halt_in;

    // IF/ID register toward decode
    logic  if_valid;
    word_t if_instr;
    word_t if_pc;
    word_t if_npc;

    // The fetch stage itself
    modport master (
        input  ihit, imemload, stall, redirect, redirect_pc, halt_in,
        output imemREN, imemaddr, if_valid, if_instr, if_pc, if_npc
    );

    // The surrounding core (icache, hazard unit, decode)
    modport slave (
        output ihit, imemload, stall, redirect, redirect_pc, halt_in,
        input  imemREN, imemaddr, if_valid, if_instr, if_pc, if_npc
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Owns the PC, requests words from the icache, and absorbs a decode stall
// that coincides with a hit in a one-entry skid buffer so the word is never
// refetched. Redirects flush the IF/ID slot; halt freezes the stage until reset.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic   CLK,
    input  logic   nRST,
    fetch_if.master bus
);

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        BUFFERED = 2'd1,
        HALTED   = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;

    logic        if_valid_q;
    logic [31:0] if_instr_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_npc_q;

    // Redirect targets are word aligned; the low two bits are dropped here.
    logic [31:0] redirect_tgt;
    assign redirect_tgt = bus.redirect_pc & 32'hFFFF_FFFC;

    // Request and address come only from registered state.
    assign bus.imemREN  = (state == FETCH);
    assign bus.imemaddr = pc;

    assign bus.if_valid = if_valid_q;
    assign bus.if_instr = if_instr_q;
    assign bus.if_pc    = if_pc_q;
    assign bus.if_npc   = if_npc_q;

    // Fetch control: halt beats redirect beats normal fetch/skid handling.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= FETCH;
            pc         <= PC_INIT;
            buf_instr  <= '0;
            buf_pc     <= '0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_npc_q   <= '0;
        end else if (state != HALTED) begin
            if (bus.halt_in) begin
                state      <= HALTED;
                if_valid_q <= 1'b0;
            end else if (bus.redirect) begin
                // Any hit this cycle belongs to the wrong path and is dropped.
                state      <= FETCH;
                pc         <= redirect_tgt;
                if_valid_q <= 1'b0;
            end else begin
                case (state)
                    FETCH: begin
                        if (bus.ihit && !bus.stall) begin
                            if_valid_q <= 1'b1;
                            if_instr_q <= bus.imemload;
                            if_pc_q    <= pc;
                            if_npc_q   <= pc + 32'd4;
                            pc         <= pc + 32'd4;
                        end else if (bus.ihit) begin
                            // Park the word so the stall costs no refetch.
                            buf_instr <= bus.imemload;
                            buf_pc    <= pc;
                            pc        <= pc + 32'd4;
                            state     <= BUFFERED;
                        end else if (!bus.stall) begin
                            if_valid_q <= 1'b0;
                        end
                    end
                    BUFFERED: begin
                        if (!bus.stall) begin
                            if_valid_q <= 1'b1;
                            if_instr_q <= buf_instr;
                            if_pc_q    <= buf_pc;
                            if_npc_q   <= buf_pc + 32'd4;
                            state      <= FETCH;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule
